mc_controller: RTL
==================

// Module: mc_controller
//
// PURPOSE
//   Multicycle main-control FSM for the MIPS datapath. It sequences one instruction over 3-5 states
//   (plus memory wait states) through a single shared instruction/data memory. It drives the
//   datapath's mux selects, write enables and the 5-bit ALU control.
//   Position: between the instruction register (op/funct), the ALU zero flag and the memory
//   handshake on one side, and the datapath control inputs on the other.
//
// PARAMETERS
//   MEM_TIMEOUT  15  max cycles a memory state waits for mem_ready before aborting (1..255)
//   CNT_W        8   width of the wait-cycle counter; must hold MEM_TIMEOUT
//
// PORTS
//   clk         in   1  rising-edge clock
//   reset       in   1  asynchronous, active-high reset
//   op          in   6  instr[31:26] from the instruction register
//   funct       in   6  instr[5:0] from the instruction register
//   zero        in   1  ALU zero flag
//   mem_ready   in   1  memory done this cycle (read data valid / write accepted)
//   mem_req     out  1  memory access request, held until mem_ready
//   memwrite    out  1  memory write strobe (valid with mem_req)
//   iord        out  1  address select: 0=pc, 1=aluout
//   irwrite     out  1  load instruction register
//   pcen        out  1  PC register enable
//   regwrite    out  1  register-file write enable
//   regdst      out  1  write register: 0=rt, 1=rd
//   memtoreg    out  1  writeback: 0=aluout, 1=memory data
//   alusrca     out  1  srca: 0=pc, 1=rs
//   alusrcb     out  2  srcb: 00=rt, 01=4, 10=signimm, 11=signimm<<2
//   pcsrc       out  2  next PC: 00=alu result, 01=aluout reg, 10=jump target
//   alucontrol  out  5  00010 add, 00110 sub, 00000 and, 00001 or, 00111 slt (bit4 always 0)
//   illegal_op  out  1  1-cycle pulse on an undecodable op/funct
//   mem_err     out  1  1-cycle pulse on a memory timeout
//
// BEHAVIOUR
//   - Reset: state <= FETCH, wait counter <= 0, illegal_op = mem_err = 0.
//     While reset is high, pcen, irwrite, regwrite, memwrite and mem_req are forced 0.
//     All other outputs take their FETCH values.
//   - Outputs are Moore, decoded from state, except:
//     - pcen = pcwrite | (branch & zero)
//     - in memory states, pcwrite, irwrite and regwrite are gated by mem_ready.
//   - Unlisted outputs are 0 in every state.
//   - States and transitions:
//     FETCH   mem_req=1, iord=0, alusrca=0, alusrcb=01, add, pcsrc=00.
//             On mem_ready: irwrite=1, pcwrite=1, -> DECODE. Otherwise stay.
//     DECODE  alusrca=0, alusrcb=11, add (branch target to aluout). Next state by op:
//             lw/sw -> MEMADR; R-type(000000) -> EXEC; beq(000100) -> BRANCH;
//             addi(001000) -> ADDIEX; j(000010) -> JUMP; otherwise illegal_op=1 -> FETCH.
//     MEMADR  alusrca=1, alusrcb=10, add -> MEMRD (lw 100011) or MEMWR (sw 101011).
//     MEMRD   mem_req=1, iord=1 -> MEMWB on mem_ready.
//     MEMWB   regdst=0, memtoreg=1, regwrite=1 -> FETCH.
//     MEMWR   mem_req=1, memwrite=1, iord=1 -> FETCH on mem_ready.
//     EXEC    alusrca=1, alusrcb=00. funct 100000 add, 100010 sub, 100100 and, 100101 or,
//             101010 slt; any other funct: illegal_op=1 -> FETCH with no writeback.
//             Valid funct -> ALUWB.
//     ALUWB   regdst=1, memtoreg=0, regwrite=1 -> FETCH.
//     BRANCH  alusrca=1, alusrcb=00, sub, branch=1, pcsrc=01 -> FETCH.
//     ADDIEX  alusrca=1, alusrcb=10, add -> ADDIWB.
//     ADDIWB  regdst=0, memtoreg=0, regwrite=1 -> FETCH.
//     JUMP    pcsrc=10, pcwrite=1 -> FETCH.
//   - Latency, with zero-wait memory (mem_ready already high):
//     lw 5; sw, R-type, addi 4; beq, j 3 cycles. Each memory wait cycle adds 1.
//   - Wait counter:
//     - Clears on entry to FETCH, MEMRD or MEMWR.
//     - Increments each cycle in one of those states while mem_ready=0.
//     - When it reaches MEM_TIMEOUT with mem_ready still 0: mem_err=1, no enables asserted,
//       state -> FETCH and counter clears. The PC is not advanced, so the fetch retries.
//   - Counter saturates; it never wraps.
//   - mem_ready is ignored outside FETCH, MEMRD and MEMWR.
//   - mem_req stays high continuously across wait cycles.
//   - Asynchronous reset mid-instruction abandons it: no partial writeback, next state FETCH.
//
// TESTING
//   1. Reset high for 3 cycles, then release, mem_ready=1 -> FETCH, mem_req=1.
//      pcen=1 and irwrite=1 in the first post-reset cycle; no enables during reset.
//   2. lw (op 100011), mem_ready=1 -> states F,D,MA,MR,MW over 5 cycles.
//      regwrite=1 only in cycle 5, with memtoreg=1 and regdst=0.
//   3. R-type sub (funct 100010) -> alucontrol=00110 in EXEC, regdst=1 in ALUWB.
//      funct 000111 -> illegal_op pulse and regwrite never asserted.
//   4. beq with zero=1 -> pcen=1 and pcsrc=01 in BRANCH.
//      With zero=0 -> pcen=0 and the next state is FETCH.
//   5. sw with mem_ready low for 4 cycles, then high -> memwrite and mem_req held high for
//      5 cycles, then FETCH; 8 cycles total.
//   6. mem_ready stuck 0 in FETCH, MEM_TIMEOUT=15 -> mem_err pulse on the 15th wait cycle,
//      pcen never asserted, FETCH re-entered; reset asserted mid-MEMRD -> FETCH, no regwrite.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle MIPS main-control FSM: sequences fetch/decode/execute/writeback over a
// shared instruction/data memory with a bounded mem_ready wait per memory state.
module mc_controller #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcen,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [4:0] alucontrol,
    output logic       illegal_op,
    output logic       mem_err
);
    // state  | meaning
    // FETCH  | read instruction at pc, pc += 4
    // DECODE | branch target into aluout, dispatch on op
    // MEMADR | effective address for lw/sw
    // MEMRD  | data read at aluout
    // MEMWB  | memory data into rt
    // MEMWR  | data write at aluout
    // EXEC   | R-type ALU op
    // ALUWB  | aluout into rd
    // BRANCH | beq compare, conditional pc update
    // ADDIEX | rs + signimm
    // ADDIWB | aluout into rt
    // JUMP   | pc <= jump target
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b00110;
    localparam logic [4:0] ALU_AND = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b00001;
    localparam logic [4:0] ALU_SLT = 5'b00111;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic mem_state, timeout;
    logic pcwrite, branch;
    logic mem_req_c, memwrite_c, irwrite_c, regwrite_c, illegal_c, mem_err_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    // Wait cycle n sees cnt_q == n-1, so the last allowed wait cycle is the abort cycle.
    assign timeout   = mem_state && !mem_ready && (cnt_q >= CNT_LAST);

    always_comb begin
        state_d    = state_q;
        mem_req_c  = 1'b0;
        memwrite_c = 1'b0;
        irwrite_c  = 1'b0;
        regwrite_c = 1'b0;
        illegal_c  = 1'b0;
        mem_err_c  = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 5'b00000;

        case (state_q)
            S_FETCH: begin
                mem_req_c  = 1'b1;
                alusrcb    = 2'b01;
                alucontrol = ALU_ADD;
                if (timeout) begin
                    mem_err_c = 1'b1;
                end else if (mem_ready) begin
                    irwrite_c = 1'b1;
                    pcwrite   = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = ALU_ADD;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
                state_d    = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req_c = 1'b1;
                iord      = 1'b1;
                if (timeout) begin
                    mem_err_c = 1'b1;
                    state_d   = S_FETCH;
                end else if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_req_c  = 1'b1;
                memwrite_c = 1'b1;
                iord       = 1'b1;
                if (timeout) begin
                    mem_err_c = 1'b1;
                    state_d   = S_FETCH;
                end else if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                alusrca = 1'b1;
                state_d = S_ALUWB;
                case (funct)
                    6'b100000: alucontrol = ALU_ADD;
                    6'b100010: alucontrol = ALU_SUB;
                    6'b100100: alucontrol = ALU_AND;
                    6'b100101: alucontrol = ALU_OR;
                    6'b101010: alucontrol = ALU_SLT;
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                branch     = 1'b1;
                pcsrc      = 2'b01;
                state_d    = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
                state_d    = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        cnt_d = cnt_q;
        if ((state_d != state_q) || timeout)
            cnt_d = '0;
        else if (mem_state && !mem_ready && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    // Side-effecting strobes are held off for the whole reset assertion.
    assign mem_req    = mem_req_c  & ~reset;
    assign memwrite   = memwrite_c & ~reset;
    assign irwrite    = irwrite_c  & ~reset;
    assign regwrite   = regwrite_c & ~reset;
    assign pcen       = (pcwrite | (branch & zero)) & ~reset;
    assign illegal_op = illegal_c  & ~reset;
    assign mem_err    = mem_err_c  & ~reset;

endmodule
